// File: rtl/serial_rx_core_pkg.sv
// Shared constants and state encoding for the serial frame receiver.
// Bit counter values name the frame position that the next sample belongs to.
package serial_rx_core_pkg;

  localparam int FRAME_W = 8;

  localparam logic [3:0] CNT_IDLE       = 4'd0;
  localparam logic [3:0] CNT_FIRST_DATA = 4'd1;
  localparam logic [3:0] CNT_LAST_DATA  = 4'd8;
  localparam logic [3:0] CNT_PARITY     = 4'd9;
  localparam logic [3:0] CNT_STOP_P     = 4'd10;
  localparam logic [3:0] CNT_STOP_NP    = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RECV      = 2'd1,
    ST_WAIT_IDLE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/serial_rx_core.sv
// Single-clock serial frame receiver: start, 8 data bits LSB first, optional parity, stop.
// One line bit per clock; a good frame updates data_out with a one-cycle data_valid strobe.
module serial_rx_core
  import serial_rx_core_pkg::*;
#(
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Rx,
  output logic [FRAME_W-1:0]  data_out,
  output logic                data_valid,
  output logic [3:0]          cnt
);

  localparam logic [3:0] STOP_CNT = PARITY_EN ? CNT_STOP_P : CNT_STOP_NP;

  rx_state_e          state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [FRAME_W-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               par_q, par_d;
  logic               par_ok_q, par_ok_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_IDLE;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      par_q    <= 1'b0;
      par_ok_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      par_q    <= par_d;
      par_ok_q <= par_ok_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    par_d    = par_q;
    par_ok_d = par_ok_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = CNT_IDLE;
        if (!Rx) begin
          state_d  = ST_RECV;
          cnt_d    = CNT_FIRST_DATA;
          par_d    = 1'b0;
          // Without a parity bit every frame passes the parity check.
          par_ok_d = 1'b1;
        end
      end

      ST_RECV: begin
        if (cnt_q >= CNT_FIRST_DATA && cnt_q <= CNT_LAST_DATA) begin
          shift_d = {Rx, shift_q[FRAME_W-1:1]};
          par_d   = par_q ^ Rx;
          cnt_d   = cnt_q + 4'd1;
        end else if (PARITY_EN && cnt_q == CNT_PARITY) begin
          par_ok_d = ((par_q ^ Rx) == PARITY_ODD);
          cnt_d    = CNT_STOP_P;
        end else if (cnt_q == STOP_CNT) begin
          cnt_d = CNT_IDLE;
          if (Rx) begin
            state_d = ST_IDLE;
            if (par_ok_q) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
          end else begin
            // Framing error or break: hold off until the line is seen idle.
            state_d = ST_WAIT_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
          cnt_d   = CNT_IDLE;
        end
      end

      ST_WAIT_IDLE: begin
        cnt_d = CNT_IDLE;
        if (Rx) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_IDLE;
      end
    endcase
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign cnt        = cnt_q;

endmodule

// File: tb/tb_serial_rx_core.sv
// Randomized frame-level bench: builds a per-cycle line schedule with expected outputs
// derived from the frame format, then replays it and compares every cycle.
`timescale 1ns/1ps
module tb_serial_rx_core;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic [3:0] cnt;

  int checks;
  int errors;

  serial_rx_core #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .Rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .cnt        (cnt)
  );

  initial clk = 1'b0;
  always #20.83 clk = ~clk;

  // One entry per clock edge: inputs applied before the edge, outputs expected after it.
  bit         rst_q[$];
  bit         rx_q[$];
  logic [3:0] exp_cnt_q[$];
  bit         exp_valid_q[$];
  logic [7:0] exp_data_q[$];
  logic [7:0] model_data;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit r, input bit line, input logic [3:0] c, input bit v);
    rst_q.push_back(r);
    rx_q.push_back(line);
    exp_cnt_q.push_back(c);
    exp_valid_q.push_back(v);
    exp_data_q.push_back(model_data);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b1, 4'd0, 1'b0);
  endtask

  task automatic add_low(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic add_reset(input bit line, input int n);
    model_data = 8'h00;
    for (int i = 0; i < n; i++) push(1'b1, line, 4'd0, 1'b0);
  endtask

  // Start bit plus the first nbits data bits of b, leaving the frame unfinished.
  task automatic add_partial(input logic [7:0] b, input int nbits);
    push(1'b0, 1'b0, 4'd1, 1'b0);
    for (int k = 0; k < nbits; k++) push(1'b0, b[k], 4'(k + 2), 1'b0);
  endtask

  task automatic add_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    bit p;
    p = ^b;                 // even parity: data bits plus parity bit XOR to zero
    if (bad_par) p = ~p;
    add_partial(b, 8);
    push(1'b0, p, 4'd10, 1'b0);
    if (bad_stop) begin
      push(1'b0, 1'b0, 4'd0, 1'b0);
    end else if (bad_par) begin
      push(1'b0, 1'b1, 4'd0, 1'b0);
    end else begin
      model_data = b;
      push(1'b0, 1'b1, 4'd0, 1'b1);
    end
  endtask

  task automatic play(input string phase);
    int n;
    n = rx_q.size();
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check_eq($sformatf("%s[%0d].cnt", phase, i - 1), 32'(cnt), 32'(exp_cnt_q[i-1]));
        check_eq($sformatf("%s[%0d].valid", phase, i - 1), 32'(data_valid), 32'(exp_valid_q[i-1]));
        check_eq($sformatf("%s[%0d].data", phase, i - 1), 32'(data_out), 32'(exp_data_q[i-1]));
        if (exp_valid_q[i-1])
          $display("rx %s edge %0d: byte %02h (dut %02h valid %0d)", phase, i - 1,
                   exp_data_q[i-1], data_out, data_valid);
      end
      if (i < n) begin
        rst = rst_q[i];
        rx  = rx_q[i];
      end
    end
    rst = 1'b0;
    rx  = 1'b1;
    rst_q.delete();
    rx_q.delete();
    exp_cnt_q.delete();
    exp_valid_q.delete();
    exp_data_q.delete();
  endtask

  initial begin
    int kind;
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    rx         = 1'b1;
    model_data = 8'h00;

    // Reset, then a long idle line.
    add_reset(1'b1, 3);
    add_idle(50);
    play("idle");

    // Single frame, then back-to-back frames with no gap.
    add_frame(8'h43, 1'b0, 1'b0);
    add_idle(2);
    add_frame(8'h43, 1'b0, 1'b0);
    add_frame(8'h4C, 1'b0, 1'b0);
    add_idle(3);
    play("good");

    // Parity error keeps the old byte; the next frame is received.
    add_frame(8'h43, 1'b1, 1'b0);
    add_frame(8'h5A, 1'b0, 1'b0);
    add_idle(2);
    play("parity");

    // Framing error, low line must not start a frame, then recovery.
    add_frame(8'hA5, 1'b0, 1'b1);
    add_low(5);
    add_idle(1);
    add_frame(8'h4C, 1'b0, 1'b0);
    add_idle(2);
    play("break");

    // Reset mid-frame at cnt==5, line low during reset to show reset priority.
    add_partial(8'h96, 4);
    add_reset(1'b0, 1);
    add_idle(4);
    add_frame(8'h3C, 1'b0, 1'b0);
    add_idle(1);
    play("midrst");

    // Random mix of good, parity-error and framing-error frames with random gaps.
    for (int f = 0; f < 40; f++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        add_frame(8'($urandom), 1'b1, 1'b0);
      end else if (kind == 1) begin
        add_frame(8'($urandom), 1'b0, 1'b1);
        add_low(int'($urandom_range(0, 5)));
        add_idle(int'($urandom_range(1, 3)));
      end else begin
        add_frame(8'($urandom), 1'b0, 1'b0);
      end
      add_idle(int'($urandom_range(0, 2)));
    end
    add_idle(2);
    play("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
